// File: rtl/rc4_prga_if.sv
// ----------------------------------------------------------------------------
// rc4_prga_if
// Bundles the control handshake and the three memory ports of the RC4
// keystream generator.
//   start   level request from the key-scheduling controller
//   done    run complete (level)
//   bad     invalid plaintext byte seen (only with PRGA_CHAR_CHECK_EN)
//   s_*     shared 256x8 S RAM port (addr/data/wren out, q in)
//   e_*     encrypted-message ROM port (addr out, q in)
//   d_*     decrypted-message RAM write port
// master: the PRGA block. slave: controller plus memories.
// ----------------------------------------------------------------------------
interface rc4_prga_if;
    logic       start;
    logic       done;
    logic       bad;
    logic [7:0] s_addr;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;
    logic [7:0] e_addr;
    logic [7:0] e_q;
    logic [7:0] d_addr;
    logic [7:0] d_data;
    logic       d_wren;

    modport master (
        input  start, s_q, e_q,
        output done, bad, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren
    );

    modport slave (
        output start, s_q, e_q,
        input  done, bad, s_addr, s_data, s_wren, e_addr, d_addr, d_data, d_wren
    );
endinterface

// File: rtl/rc4_prga.sv
// ----------------------------------------------------------------------------
// rc4_prga
// RC4 pseudo-random generation stage. Walks the already-permuted S RAM,
// swaps S[i]/S[j] for every byte, and writes keystream XOR ciphertext into
// the decrypted-message RAM. Each byte takes exactly nine cycles.
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset
//   bus     rc4_prga_if.master: start/done/bad plus S, E and D memory ports
// Parameters:
//   MSG_LEN number of message bytes processed (1..256)
// Build option:
//   PRGA_CHAR_CHECK_EN  when defined, stop early with bad=1 on the first
//                       decrypted byte that is neither space nor 'a'..'z'.
// Memories have one cycle of read latency: address in cycle N, q in N+1.
// ----------------------------------------------------------------------------
module rc4_prga #(
    parameter int unsigned MSG_LEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    rc4_prga_if.master   bus
);

    typedef enum logic [3:0] {
        StIdle, StRdI, StLdI, StRdJ, StLdJ, StWrI, StWrJ, StRdF, StLdF, StWrD, StDone
    } state_e;

    localparam logic [8:0] LastK = 9'(MSG_LEN - 1);

    state_e     r_state, w_state_d;
    logic [7:0] r_i, w_i_d;
    logic [7:0] r_j, w_j_d;
    logic [8:0] r_k, w_k_d;
    logic [7:0] r_si, w_si_d;
    logic [7:0] r_sj, w_sj_d;
    logic [7:0] r_f, w_f_d;
    logic [7:0] w_dec;
    logic       w_invalid;

    // e_q holds ciphertext byte k for the whole byte slot because the ROM
    // address only changes when k advances at the end of WR_D.
    assign w_dec      = r_f ^ bus.e_q;
    assign bus.e_addr = r_k[7:0];

`ifdef PRGA_CHAR_CHECK_EN
    logic r_bad;

    assign w_invalid = !((w_dec == 8'h20) || ((w_dec >= 8'h61) && (w_dec <= 8'h7a)));
    assign bus.bad   = r_bad;

    // Sticky until reset or until a fresh run is accepted from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bad <= 1'b0;
        end else if (r_state == StIdle && bus.start) begin
            r_bad <= 1'b0;
        end else if (r_state == StWrD && w_invalid) begin
            r_bad <= 1'b1;
        end
    end
`else
    assign w_invalid = 1'b0;
    assign bus.bad   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= 9'd0;
            r_si    <= 8'd0;
            r_sj    <= 8'd0;
            r_f     <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_i     <= w_i_d;
            r_j     <= w_j_d;
            r_k     <= w_k_d;
            r_si    <= w_si_d;
            r_sj    <= w_sj_d;
            r_f     <= w_f_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_i_d      = r_i;
        w_j_d      = r_j;
        w_k_d      = r_k;
        w_si_d     = r_si;
        w_sj_d     = r_sj;
        w_f_d      = r_f;
        bus.done   = 1'b0;
        bus.s_addr = 8'd0;
        bus.s_data = 8'd0;
        bus.s_wren = 1'b0;
        bus.d_addr = 8'd0;
        bus.d_data = 8'd0;
        bus.d_wren = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_i_d     = 8'd1;
                    w_j_d     = 8'd0;
                    w_k_d     = 9'd0;
                    w_state_d = StRdI;
                end
            end
            StRdI: begin
                bus.s_addr = r_i;
                w_state_d  = StLdI;
            end
            StLdI: begin
                w_si_d    = bus.s_q;
                w_j_d     = r_j + bus.s_q;
                w_state_d = StRdJ;
            end
            StRdJ: begin
                bus.s_addr = r_j;
                w_state_d  = StLdJ;
            end
            StLdJ: begin
                w_sj_d    = bus.s_q;
                w_state_d = StWrI;
            end
            StWrI: begin
                bus.s_addr = r_i;
                bus.s_data = r_sj;
                bus.s_wren = 1'b1;
                w_state_d  = StWrJ;
            end
            // When i==j both writes hit one address with the same value.
            StWrJ: begin
                bus.s_addr = r_j;
                bus.s_data = r_si;
                bus.s_wren = 1'b1;
                w_state_d  = StRdF;
            end
            StRdF: begin
                bus.s_addr = r_si + r_sj;
                w_state_d  = StLdF;
            end
            StLdF: begin
                w_f_d     = bus.s_q;
                w_state_d = StWrD;
            end
            StWrD: begin
                bus.d_addr = r_k[7:0];
                bus.d_data = w_dec;
                bus.d_wren = 1'b1;
                if (r_k == LastK || w_invalid) begin
                    w_state_d = StDone;
                end else begin
                    w_k_d     = r_k + 9'd1;
                    w_i_d     = r_i + 8'd1;
                    w_state_d = StRdI;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                if (!bus.start) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule
